// File: rtl/dep_matrix_scheduler_if.sv
// Handshake bundle between the instruction buffer allocator, the completion
// broadcast network and functional-unit dispatch on one side, and the
// dependency matrix scheduler on the other.
//   alloc_valid/alloc_index/alloc_deps : write a new entry and its dependencies
//   complete_valid/complete_index      : CW completion broadcast ports
//   issue_ready                        : dispatch accepts slot k
//   issue_valid/issue_index            : IW issue offers
//   ready_positions                    : per-entry ready vector
//   occupancy/full                     : count of non-free entries
//   alloc_error                        : sticky illegal-alloc flag
// master = environment driving the scheduler, slave = the scheduler itself.
interface dep_matrix_scheduler_if #(
  parameter int BS  = 16,
  parameter int IW  = 2,
  parameter int CW  = 2,
  parameter int IXW = $clog2(BS)
);
  logic                     alloc_valid;
  logic [IXW-1:0]           alloc_index;
  logic [BS-1:0]            alloc_deps;
  logic [CW-1:0]            complete_valid;
  logic [CW*IXW-1:0]        complete_index;
  logic [IW-1:0]            issue_ready;
  logic [IW-1:0]            issue_valid;
  logic [IW*IXW-1:0]        issue_index;
  logic [BS-1:0]            ready_positions;
  logic [$clog2(BS+1)-1:0]  occupancy;
  logic                     full;
  logic                     alloc_error;

  modport master (
    output alloc_valid, alloc_index, alloc_deps,
    output complete_valid, complete_index, issue_ready,
    input  issue_valid, issue_index, ready_positions,
    input  occupancy, full, alloc_error
  );

  modport slave (
    input  alloc_valid, alloc_index, alloc_deps,
    input  complete_valid, complete_index, issue_ready,
    output issue_valid, issue_index, ready_positions,
    output occupancy, full, alloc_error
  );
endinterface

// File: rtl/dep_matrix_scheduler.sv
// Dependency matrix scheduler: BS entries, each with a FREE/WAITING/ISSUED
// state and a BS-bit mask of entries it still waits on. Completions clear
// their column and free the entry; up to IW ready entries are offered per
// cycle in round-robin order starting at prio_base.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : dep_matrix_scheduler_if slave modport (alloc, complete, issue,
//         ready_positions, occupancy, full, alloc_error)
module dep_matrix_scheduler #(
  parameter int BS = 16,
  parameter int IW = 2,
  parameter int CW = 2
) (
  input logic                   clk,
  input logic                   rst,
  dep_matrix_scheduler_if.slave bus
);
  localparam int IXW = $clog2(BS);
  localparam int OW  = $clog2(BS + 1);
  localparam logic [IXW-1:0] IDX_ONE = IXW'(1);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } ent_st_t;

  ent_st_t        st       [BS];
  ent_st_t        st_nxt   [BS];
  logic [BS-1:0]  mask     [BS];
  logic [BS-1:0]  mask_nxt [BS];
  logic [IXW-1:0] prio_base, prio_nxt;
  logic           err, err_nxt;
  logic [OW-1:0]  occ, occ_nxt;

  logic [BS-1:0]  rdy;
  logic [BS-1:0]  free_vec;
  logic [BS-1:0]  comp_eff;
  logic [BS-1:0]  grant;
  logic [IW-1:0]  sel_vld;
  logic [IXW-1:0] sel_idx [IW];

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      rdy[i]      = (st[i] == ST_WAIT) && (mask[i] == '0);
      free_vec[i] = (st[i] == ST_FREE);
    end
  end

  // Round-robin pick: slot k takes the (k+1)-th ready entry at or after
  // prio_base. The taken vector keeps slot offers distinct.
  always_comb begin
    logic [BS-1:0]  taken;
    logic [IXW-1:0] cand;
    logic           found;
    taken = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < IW; k++) begin
      sel_vld[k] = 1'b0;
      sel_idx[k] = '0;
      found      = 1'b0;
      for (int o = 0; o < BS; o++) begin
        cand = prio_base + IXW'(o);
        if (!found && rdy[cand] && !taken[cand]) begin
          found      = 1'b1;
          sel_vld[k] = 1'b1;
          sel_idx[k] = cand;
        end
      end
      if (found) taken[sel_idx[k]] = 1'b1;
    end
  end

  always_comb begin
    bus.issue_valid = sel_vld;
    bus.issue_index = '0;
    for (int k = 0; k < IW; k++) bus.issue_index[k*IXW +: IXW] = sel_idx[k];
  end

  assign bus.ready_positions = rdy;
  assign bus.occupancy       = occ;
  assign bus.full            = (occ == OW'(BS));
  assign bus.alloc_error     = err;

  always_comb begin
    logic [IXW-1:0] ci;
    logic [OW-1:0]  ncomp;
    logic           alloc_ok;
    logic [BS-1:0]  alloc_mask;
    ci       = '0;
    ncomp    = '0;
    comp_eff = '0;
    grant    = '0;
    prio_nxt = prio_base;

    // Only an ISSUED entry can complete; duplicates merge in the bit vector.
    for (int p = 0; p < CW; p++) begin
      ci = bus.complete_index[p*IXW +: IXW];
      if (bus.complete_valid[p] && (st[ci] == ST_ISSUED)) comp_eff[ci] = 1'b1;
    end

    // Later slots override, so prio_base follows the highest accepted slot.
    for (int k = 0; k < IW; k++) begin
      if (sel_vld[k] && bus.issue_ready[k]) begin
        grant[sel_idx[k]] = 1'b1;
        prio_nxt          = sel_idx[k] + IDX_ONE;
      end
    end

    alloc_ok = bus.alloc_valid && (st[bus.alloc_index] == ST_FREE);
    err_nxt  = err | (bus.alloc_valid && !alloc_ok);
    // The self bit is always dropped here: the target entry is FREE.
    alloc_mask = bus.alloc_deps & ~free_vec & ~comp_eff;

    for (int i = 0; i < BS; i++) begin
      st_nxt[i]   = st[i];
      mask_nxt[i] = mask[i] & ~comp_eff;
      case (st[i])
        ST_WAIT:   if (grant[i]) st_nxt[i] = ST_ISSUED;
        ST_ISSUED: if (comp_eff[i]) st_nxt[i] = ST_FREE;
        ST_FREE: begin
          if (alloc_ok && (bus.alloc_index == IXW'(i))) begin
            st_nxt[i]   = ST_WAIT;
            mask_nxt[i] = alloc_mask;
          end
        end
        default: st_nxt[i] = ST_FREE;
      endcase
    end

    for (int i = 0; i < BS; i++) ncomp = ncomp + OW'(comp_eff[i]);
    occ_nxt = occ + OW'(alloc_ok) - ncomp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        st[i]   <= ST_FREE;
        mask[i] <= '0;
      end
      prio_base <= '0;
      err       <= 1'b0;
      occ       <= '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        st[i]   <= st_nxt[i];
        mask[i] <= mask_nxt[i];
      end
      prio_base <= prio_nxt;
      err       <= err_nxt;
      occ       <= occ_nxt;
    end
  end
endmodule

// File: tb/tb_dep_matrix_scheduler.sv
// Self-checking bench for dep_matrix_scheduler: directed scenarios with
// literal expectations followed by randomized traffic, all compared every
// cycle against an entry-list model of the scheduler.
module tb_dep_matrix_scheduler;
  localparam int BS  = 16;
  localparam int IW  = 2;
  localparam int CW  = 2;
  localparam int IXW = 4;
  localparam int M_FREE = 0, M_WAIT = 1, M_ISS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dep_matrix_scheduler_if #(.BS(BS), .IW(IW), .CW(CW)) bus ();
  dep_matrix_scheduler #(.BS(BS), .IW(IW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  int            m_st   [BS];
  logic [BS-1:0] m_mask [BS];
  int            m_prio;
  bit            m_err;
  bit            off_vld [IW];
  int            off_idx [IW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  function automatic void reset_model();
    for (int i = 0; i < BS; i++) begin
      m_st[i]   = M_FREE;
      m_mask[i] = '0;
    end
    m_prio = 0;
    m_err  = 1'b0;
  endfunction

  function automatic logic [BS-1:0] model_ready();
    logic [BS-1:0] r;
    r = '0;
    for (int i = 0; i < BS; i++) r[i] = (m_st[i] == M_WAIT) && (m_mask[i] == '0);
    return r;
  endfunction

  // Build the ordered list of ready entries from prio_base, then hand out.
  function automatic void compute_offers();
    int q[$];
    logic [BS-1:0] r;
    r = model_ready();
    for (int o = 0; o < BS; o++)
      if (r[(m_prio + o) % BS]) q.push_back((m_prio + o) % BS);
    for (int k = 0; k < IW; k++) begin
      off_vld[k] = (k < q.size());
      off_idx[k] = (k < q.size()) ? q[k] : 0;
    end
  endfunction

  task automatic check_outputs();
    logic [IW-1:0]     ev;
    logic [IW*IXW-1:0] ei;
    int                occ;
    compute_offers();
    ev  = '0;
    ei  = '0;
    occ = 0;
    for (int k = 0; k < IW; k++) begin
      ev[k] = off_vld[k];
      ei[k*IXW +: IXW] = IXW'(off_idx[k]);
    end
    for (int i = 0; i < BS; i++) if (m_st[i] != M_FREE) occ++;
    chk("ready_positions", 64'(bus.ready_positions), 64'(model_ready()));
    chk("issue_valid", 64'(bus.issue_valid), 64'(ev));
    chk("issue_index", 64'(bus.issue_index), 64'(ei));
    chk("occupancy", 64'(bus.occupancy), 64'(occ));
    chk("full", 64'(bus.full), 64'(occ == BS));
    chk("alloc_error", 64'(bus.alloc_error), 64'(m_err));
  endtask

  // Apply one clock edge's worth of the rules to the model.
  task automatic model_step();
    logic [BS-1:0] comp, freev, acc;
    int            hi, ai, ci;
    bit            legal;
    if (rst) begin
      reset_model();
      return;
    end
    comp  = '0;
    freev = '0;
    acc   = '0;
    hi    = -1;
    for (int i = 0; i < BS; i++) freev[i] = (m_st[i] == M_FREE);
    for (int p = 0; p < CW; p++) begin
      ci = int'(bus.complete_index[p*IXW +: IXW]);
      if (bus.complete_valid[p] && m_st[ci] == M_ISS) comp[ci] = 1'b1;
    end
    for (int k = 0; k < IW; k++)
      if (off_vld[k] && bus.issue_ready[k]) begin
        acc[off_idx[k]] = 1'b1;
        hi = off_idx[k];
      end
    ai    = int'(bus.alloc_index);
    legal = bus.alloc_valid && (m_st[ai] == M_FREE);
    if (bus.alloc_valid && !legal) m_err = 1'b1;
    for (int i = 0; i < BS; i++) begin
      m_mask[i] = m_mask[i] & ~comp;
      if (acc[i]) m_st[i] = M_ISS;
      if (comp[i]) m_st[i] = M_FREE;
    end
    if (legal) begin
      m_st[ai]   = M_WAIT;
      m_mask[ai] = bus.alloc_deps & ~freev & ~comp;
      m_mask[ai][ai] = 1'b0;
    end
    if (hi >= 0) m_prio = (hi + 1) % BS;
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst                = 1'b0;
    bus.alloc_valid    = 1'b0;
    bus.alloc_index    = '0;
    bus.alloc_deps     = '0;
    bus.complete_valid = '0;
    bus.complete_index = '0;
    bus.issue_ready    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input int idx, input logic [BS-1:0] deps);
    idle();
    bus.alloc_valid = 1'b1;
    bus.alloc_index = IXW'(idx);
    bus.alloc_deps  = deps;
    tick();
  endtask

  initial begin
    int          fq[$];
    int          iq[$];
    logic [31:0] r32;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (3) tick();
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_ready", 64'(bus.ready_positions), 64'd0);

    // Chain 3 -> 5
    alloc(3, 16'h0000);
    chk("chain_valid", 64'(bus.issue_valid), 64'h1);
    chk("chain_idx3", 64'(bus.issue_index), 64'h03);
    alloc(5, 16'h0008);
    bus.issue_ready = '1;
    tick();
    idle();
    bus.complete_valid = 2'b01;
    bus.complete_index = {4'd0, 4'd3};
    tick();
    chk("chain_ready5", 64'(bus.ready_positions), 64'h0020);
    chk("chain_valid5", 64'(bus.issue_valid), 64'h1);
    chk("chain_idx5", 64'(bus.issue_index), 64'h05);

    // Round-robin with a stalled slot
    do_reset();
    alloc(1, '0);
    alloc(2, '0);
    alloc(7, '0);
    chk("rr_offer12", 64'(bus.issue_index), 64'h21);
    idle();
    bus.issue_ready = 2'b01;
    tick();
    chk("rr_offer27", 64'(bus.issue_index), 64'h72);
    chk("rr_ready", 64'(bus.ready_positions), 64'h0084);

    // Alloc mask filtering: self, FREE and completing bits dropped
    do_reset();
    alloc(6, '0);
    idle();
    bus.issue_ready = 2'b01;
    tick();
    idle();
    bus.alloc_valid    = 1'b1;
    bus.alloc_index    = 4'd4;
    bus.alloc_deps     = 16'h0250;
    bus.complete_valid = 2'b01;
    bus.complete_index = {4'd0, 4'd6};
    tick();
    chk("filt_ready4", 64'(bus.ready_positions), 64'h0010);
    chk("filt_occ", 64'(bus.occupancy), 64'd1);

    // Full buffer and the sticky error
    do_reset();
    for (int i = 0; i < BS; i++) alloc(i, '0);
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_occ", 64'(bus.occupancy), 64'd16);
    alloc(0, 16'hFFFF);
    chk("fill_err", 64'(bus.alloc_error), 64'd1);
    chk("fill_ready", 64'(bus.ready_positions), 64'hFFFF);
    do_reset();
    chk("fill_err_clr", 64'(bus.alloc_error), 64'd0);
    chk("fill_occ_clr", 64'(bus.occupancy), 64'd0);

    // Completion on WAITING ignored; duplicate ports merge
    alloc(2, '0);
    idle();
    bus.complete_valid = 2'b01;
    bus.complete_index = {4'd0, 4'd2};
    tick();
    chk("cw_occ", 64'(bus.occupancy), 64'd1);
    chk("cw_ready", 64'(bus.ready_positions), 64'h0004);
    idle();
    bus.issue_ready = 2'b01;
    tick();
    idle();
    bus.complete_valid = 2'b11;
    bus.complete_index = {4'd2, 4'd2};
    tick();
    chk("dup_occ", 64'(bus.occupancy), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      fq.delete();
      iq.delete();
      for (int i = 0; i < BS; i++) begin
        if (m_st[i] == M_FREE) fq.push_back(i);
        if (m_st[i] == M_ISS) iq.push_back(i);
      end
      rst = ($urandom_range(0, 299) == 0);
      bus.alloc_valid = $urandom_range(0, 1) == 1;
      if (fq.size() > 0 && $urandom_range(0, 3) != 0)
        bus.alloc_index = IXW'(fq[$urandom_range(0, fq.size() - 1)]);
      else
        bus.alloc_index = IXW'($urandom_range(0, BS - 1));
      r32 = $urandom & $urandom & $urandom;
      bus.alloc_deps = r32[BS-1:0];
      for (int p = 0; p < CW; p++) begin
        bus.complete_valid[p] = $urandom_range(0, 9) < 4;
        if (iq.size() > 0 && $urandom_range(0, 4) != 0)
          bus.complete_index[p*IXW +: IXW] = IXW'(iq[$urandom_range(0, iq.size() - 1)]);
        else
          bus.complete_index[p*IXW +: IXW] = IXW'($urandom_range(0, BS - 1));
      end
      r32 = $urandom;
      bus.issue_ready = r32[IW-1:0];
      tick();
    end

    idle();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
